// File: rtl/knn_query_scheduler_if.sv
// Query and result valid/ready streams of the kNN query scheduler.
// The slave modport is the scheduler's view; master is the producer/consumer side.
interface knn_query_scheduler_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             s_valid;
  logic             s_ready;
  logic [63:0]      s_vector;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       m_class;
  logic [19:0]      m_top5;
  logic [TAG_W-1:0] m_tag;

  modport master (
    output s_valid, s_vector, s_tag, m_ready,
    input  s_ready, m_valid, m_class, m_top5, m_tag
  );

  modport slave (
    input  s_valid, s_vector, s_tag, m_ready,
    output s_ready, m_valid, m_class, m_top5, m_tag
  );
endinterface

// File: rtl/knn_query_scheduler.sv
// Buffers tagged queries, sequences the start/done-less kNN core with a reset pulse and a
// fixed-latency counter, and returns the captured classes on a result stream.
module knn_query_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LATENCY    = 158,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  knn_query_scheduler_if.slave bus,
  output logic                 core_rst_n,
  output logic [63:0]          core_vector,
  input  logic [19:0]          core_top5,
  input  logic [3:0]           core_class,
  output logic                 busy,
  output logic [CNT_W-1:0]     query_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LatW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StWaitOut} state_e;

  logic [TAG_W+63:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;
  state_e            r_state;
  state_e            w_state_next;
  logic [LatW-1:0]   r_lat_cnt;
  logic              r_core_rst_n;
  logic [63:0]       r_core_vector;
  logic [TAG_W-1:0]  r_tag;
  logic              r_m_valid;
  logic [3:0]        r_m_class;
  logic [19:0]       r_m_top5;
  logic [TAG_W-1:0]  r_m_tag;
  logic [CNT_W-1:0]  r_query_count;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_slot_free;
  logic              w_capture;
  logic              w_handshake;
  logic [TAG_W+63:0] w_head;

  assign w_empty     = (r_count == '0);
  assign bus.s_ready = (r_count != (PtrW + 1)'(FIFO_DEPTH));
  assign w_push      = bus.s_valid & bus.s_ready;
  assign w_pop       = (r_state == StIdle) & ~w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_handshake = r_m_valid & bus.m_ready;
  assign w_slot_free = ~r_m_valid | bus.m_ready;

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.s_tag, bus.s_vector};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) w_state_next = StLoad;
      end
      StLoad: begin
        w_state_next = StRun;
      end
      StRun: begin
        if (r_lat_cnt == LatW'(LATENCY - 1)) begin
          if (w_slot_free) begin
            w_capture    = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StWaitOut;
          end
        end
      end
      StWaitOut: begin
        if (w_slot_free) begin
          w_capture    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Core stays out of reset while its result is pending so its outputs remain stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_lat_cnt     <= '0;
      r_core_rst_n  <= 1'b0;
      r_core_vector <= '0;
      r_tag         <= '0;
    end else begin
      r_state      <= w_state_next;
      r_core_rst_n <= (w_state_next == StRun) | (w_state_next == StWaitOut);
      if (r_state == StLoad) begin
        r_lat_cnt <= '0;
      end else if (r_state == StRun) begin
        r_lat_cnt <= r_lat_cnt + LatW'(1);
      end
      if (w_pop) begin
        r_core_vector <= w_head[63:0];
        r_tag         <= w_head[TAG_W+63:64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid     <= 1'b0;
      r_m_class     <= '0;
      r_m_top5      <= '0;
      r_m_tag       <= '0;
      r_query_count <= '0;
    end else begin
      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_class <= core_class;
        r_m_top5  <= core_top5;
        r_m_tag   <= r_tag;
      end else if (w_handshake) begin
        r_m_valid <= 1'b0;
      end
      if (w_handshake) r_query_count <= r_query_count + CNT_W'(1);
    end
  end

  assign bus.m_valid = r_m_valid;
  assign bus.m_class = r_m_class;
  assign bus.m_top5  = r_m_top5;
  assign bus.m_tag   = r_m_tag;
  assign core_rst_n  = r_core_rst_n;
  assign core_vector = r_core_vector;
  assign busy        = (r_state != StIdle);
  assign query_count = r_query_count;

endmodule

// File: tb/tb_knn_query_scheduler.sv
// Directed bench for knn_query_scheduler with a stub core whose outputs are slices of
// core_vector, so every expected class/top5 value is hand-derivable from the query.
module tb_knn_query_scheduler;

  localparam int unsigned LATENCY = 158;

  typedef struct {
    logic [63:0] vec;
    logic [3:0]  tag;
    logic [3:0]  cls;
    logic [19:0] top5;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        core_rst_n;
  logic [63:0] core_vector;
  logic [19:0] core_top5;
  logic [3:0]  core_class;
  logic        busy;
  logic [3:0]  query_count;

  int          n_cmp;
  int          n_err;
  int          cyc;
  logic [3:0]  exp_cnt;
  vec_t        tbl [4];

  knn_query_scheduler_if #(.TAG_W(4)) bus ();

  knn_query_scheduler #(
    .FIFO_DEPTH(4),
    .LATENCY   (LATENCY),
    .TAG_W     (4),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .core_vector(core_vector),
    .core_top5  (core_top5),
    .core_class (core_class),
    .busy       (busy),
    .query_count(query_count)
  );

  // Stub core: class = low nibble, top5 = upper 20 bits, zero while held in reset.
  assign core_class = core_rst_n ? core_vector[3:0] : 4'h0;
  assign core_top5  = core_rst_n ? core_vector[63:44] : 20'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (bus.m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: m_valid timeout, got 0, expected 1", name);
    end
  endtask

  // One query through an idle scheduler with m_ready=1, checking the full timeline.
  task automatic run_single(input vec_t r);
    int e0;
    bit ok;
    check("s_ready_idle", bus.s_ready, 1);
    bus.s_valid  = 1'b1;
    bus.s_vector = r.vec;
    bus.s_tag    = r.tag;
    tick();
    e0 = cyc;
    bus.s_valid = 1'b0;
    check("busy_e0", busy, 0);
    tick();
    check("busy_load", busy, 1);
    check("core_rst_load", core_rst_n, 0);
    check("core_vec_load", core_vector, r.vec);
    tick();
    check("core_rst_run", core_rst_n, 1);
    wait_valid("single", ok);
    if (ok) begin
      check("latency", cyc - e0, LATENCY + 2);
      check("m_class", bus.m_class, r.cls);
      check("m_top5", bus.m_top5, r.top5);
      check("m_tag", bus.m_tag, r.tag);
      check("core_vec_held", core_vector, r.vec);
      tick();
      exp_cnt++;
      check("m_valid_drop", bus.m_valid, 0);
      check("query_count", query_count, exp_cnt);
      check("busy_done", busy, 0);
    end
  endtask

  initial begin
    int a0;
    int b0;
    int c0;
    int bad;
    bit ok;

    tbl[0] = '{vec: 64'h0064_00C8_0096_0032, tag: 4'd5,  cls: 4'h2, top5: 20'h00640};
    tbl[1] = '{vec: 64'hABCD_1234_5678_9EF1, tag: 4'd3,  cls: 4'h1, top5: 20'hABCD1};
    tbl[2] = '{vec: 64'hFFFF_0000_0000_000F, tag: 4'd15, cls: 4'hF, top5: 20'hFFFF0};
    tbl[3] = '{vec: 64'h1357_9BDF_2468_ACE0, tag: 4'd0,  cls: 4'h0, top5: 20'h13579};

    n_cmp        = 0;
    n_err        = 0;
    exp_cnt      = 4'd0;
    rst_n        = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_vector = tbl[0].vec;
    bus.s_tag    = 4'd5;
    bus.m_ready  = 1'b1;

    // Reset with s_valid held high: nothing may be queued.
    repeat (3) tick();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_query_count", query_count, 0);
    check("rst_busy", busy, 0);
    check("rst_core_vector", core_vector, 0);
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    check("rel_s_ready", bus.s_ready, 1);
    tick();
    check("rel_no_pop", busy, 0);

    for (int i = 0; i < 4; i++) run_single(tbl[i]);

    // Burst of six: five accepted, sixth refused while the FIFO is full.
    for (int i = 0; i < 6; i++) begin
      bus.s_valid  = 1'b1;
      bus.s_vector = tbl[i % 4].vec;
      bus.s_tag    = 4'(i + 1);
      check(i == 5 ? "burst_full" : "burst_ready", bus.s_ready, i == 5 ? 1'b0 : 1'b1);
      tick();
      if (i == 0) a0 = cyc;
    end
    check("burst_still_full", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("burst", ok);
      if (!ok) break;
      check("burst_tag", bus.m_tag, 4'(i + 1));
      check("burst_class", bus.m_class, tbl[i % 4].cls);
      check("burst_top5", bus.m_top5, tbl[i % 4].top5);
      check("burst_spacing", cyc - a0, (LATENCY + 2) * (i + 1));
      tick();
      exp_cnt++;
    end
    check("burst_count", query_count, exp_cnt);

    // Backpressure: first result held, second completion parks in WAIT_OUT.
    bus.m_ready  = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_vector = tbl[2].vec;
    bus.s_tag    = 4'd7;
    tick();
    b0           = cyc;
    bus.s_vector = tbl[3].vec;
    bus.s_tag    = 4'd8;
    tick();
    bus.s_valid = 1'b0;
    wait_valid("bp_first", ok);
    check("bp_first_time", cyc - b0, LATENCY + 2);
    repeat (10) tick();
    check("bp_hold_valid", bus.m_valid, 1);
    check("bp_hold_tag", bus.m_tag, 7);
    check("bp_hold_class", bus.m_class, tbl[2].cls);
    while (cyc < b0 + 2 * (LATENCY + 2) + 5) tick();
    check("bp_wait_busy", busy, 1);
    check("bp_wait_core_rst", core_rst_n, 1);
    check("bp_wait_core_vec", core_vector, tbl[3].vec);
    check("bp_wait_tag", bus.m_tag, 7);
    check("bp_wait_top5", bus.m_top5, tbl[2].top5);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    exp_cnt++;
    check("bp_swap_valid", bus.m_valid, 1);
    check("bp_swap_tag", bus.m_tag, 8);
    check("bp_swap_class", bus.m_class, tbl[3].cls);
    check("bp_swap_top5", bus.m_top5, tbl[3].top5);
    check("bp_swap_count", query_count, exp_cnt);
    check("bp_swap_idle", busy, 0);
    tick();
    check("bp_second_hold", bus.m_tag, 8);
    bus.m_ready = 1'b1;
    tick();
    exp_cnt++;
    check("bp_drain_valid", bus.m_valid, 0);
    check("bp_drain_count", query_count, exp_cnt);

    // Reset 50 cycles into RUN with a second query still queued.
    bus.s_valid  = 1'b1;
    bus.s_vector = tbl[0].vec;
    bus.s_tag    = 4'd9;
    tick();
    c0           = cyc;
    bus.s_vector = tbl[1].vec;
    bus.s_tag    = 4'd10;
    tick();
    bus.s_valid = 1'b0;
    while (cyc < c0 + 52) tick();
    check("abort_pre_busy", busy, 1);
    check("abort_pre_core_rst", core_rst_n, 1);
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    exp_cnt = 4'd0;
    check("abort_busy", busy, 0);
    check("abort_core_rst", core_rst_n, 0);
    check("abort_m_valid", bus.m_valid, 0);
    check("abort_count", query_count, 0);
    check("abort_s_ready", bus.s_ready, 1);
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.m_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    check("abort_quiet", bad, 0);
    run_single(tbl[0]);

    // Counter wrap with a 4-bit query_count: passes 15 -> 0 -> 1.
    for (int i = 0; i < 17; i++) run_single(tbl[i % 4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/knn_query_scheduler.md
Name: knn_query_scheduler

Overview:
Front-end controller for the knn_classification core.
- Accepts tagged 64-bit query vectors over a valid/ready stream and buffers them in a small FIFO.
- Runs one query at a time through the core. The core has no start or done signals, so the block sequences it with a one-cycle core reset pulse and a fixed-latency counter.
- Captures the top-5 classes and the voted class, then returns them in order on a valid/ready result stream.

Parameters:
FIFO_DEPTH, 4, query FIFO entries (power of 2, ≥2)
LATENCY, 158, core cycles from core reset release to stable result
TAG_W, 4, width of the query tag carried through to the result
CNT_W, 16, width of the completed-query counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
s_valid  input  1  query valid
s_ready  output  1  query accepted when s_valid&s_ready at posedge
s_vector  input  64  query features {f0,f1,f2,f3}, 16 b each
s_tag  input  TAG_W  query tag
core_rst_n  output  1  drives core rst_n (registered)
core_vector  output  64  drives core test_vector (registered)
core_top5  input  20  {c1,c2,c3,c4,c5} from core, 4 b each
core_class  input  4  core final_class
m_valid  output  1  result valid
m_ready  input  1  result consumed when m_valid&m_ready at posedge
m_class  output  4  voted class
m_top5  output  20  captured {c1..c5}
m_tag  output  TAG_W  tag of the originating query
busy  output  1  high when the FSM is not in IDLE
query_count  output  CNT_W  completed results, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous, active-low, clk only.
  - Reset values: m_valid=0; m_class, m_top5, m_tag, core_vector, query_count all 0; core_rst_n=0; busy=0; FIFO empty; s_ready=1 the cycle after reset deasserts; FSM=IDLE.
  - Reset mid-operation aborts the current query and discards all FIFO contents. No result is produced for aborted queries.
- FIFO:
  - s_ready = (count != FIFO_DEPTH), decoded from registered count.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved.
- FSM states and transitions:
  - IDLE: core_rst_n=0. If FIFO non-empty: pop the head into core_vector and the tag register, then go to LOAD.
  - LOAD (exactly 1 cycle): core_rst_n=0 and core_vector stable; clear the latency counter; go to RUN.
  - RUN: core_rst_n=1; the counter increments each cycle. On the edge where counter==LATENCY-1:
    - If the output slot is free (m_valid==0, or m_valid&m_ready this cycle): capture core_class/core_top5/tag into m_*, set m_valid=1, go to IDLE.
    - Otherwise go to WAIT_OUT.
  - WAIT_OUT: core_rst_n=1 and core_vector held, so core outputs stay stable. Capture on the first cycle the slot frees (m_ready high), then go to IDLE.
- Latency: if a query is accepted at edge E0 with FIFO empty, FSM in IDLE and m_ready=1, then:
  - core_rst_n is low in the cycle after E0+1;
  - m_valid rises at edge E0+LATENCY+2.
  - Back-to-back throughput is one result per LATENCY+2 cycles.
- Output stream:
  - m_* stay stable while m_valid & !m_ready.
  - m_valid clears on handshake unless a new capture happens on the same edge, in which case the new data is loaded and m_valid stays 1.
- query_count increments on each m_valid&m_ready handshake and wraps to 0.
- core_vector changes only on a pop in IDLE and is never modified in LOAD/RUN/WAIT_OUT.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with s_valid=1 -> no push; m_valid=0, core_rst_n=0, query_count=0, busy=0; s_ready=1 after release.
2. Single query {16'd100,16'd200,16'd150,16'd50}, tag 5, accepted at E0, m_ready=1 -> core_rst_n low exactly one cycle (E1–E2); m_valid high only in the cycle after E0+160; m_tag=5; m_class/m_top5 match the core outputs at E0+160; query_count=1.
3. Burst: drive 6 queries on consecutive cycles with tags 1..6 -> tags 1–5 accepted and s_ready=0 on the 6th until the next pop. Results return in tag order 1..5, spaced 160 cycles apart.
4. Backpressure: m_ready=0 with 2 queries queued -> first result held stable; FSM enters WAIT_OUT at the second completion with core_rst_n=1. Raise m_ready for 1 cycle -> second result appears on the same edge with m_valid continuous.
5. Mid-run reset: pulse rst_n=0 at cycle 50 of RUN with 2 queries queued -> FIFO empty, m_valid never asserts, core_rst_n=0, busy=0; a new query afterwards completes with nominal latency.
6. Counter wrap (CNT_W=4): complete 17 queries -> query_count reads 15 then 0 then 1.
